// File: rtl/uart_txsm.sv
// UART transmit FSM: pops THR, sends start/data(LSB first)/parity/stop on TxD; TxD lags state by one Clk.
// Paced only by CE_16x; waits in Idle while THR_EF. Optional UART_TX_BREAK_EN adds Break (forces TxD low).
module uart_txsm #(
  parameter int DIV_BITS = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       CE_16x,
  input  logic       Len,
  input  logic       NumStop,
  input  logic       ParEn,
  input  logic [1:0] Par,
  input  logic [7:0] THR,
  input  logic       THR_EF,
`ifdef UART_TX_BREAK_EN
  input  logic       Break,
`endif
  output logic       RE_THR,
  output logic       TxD,
  output logic       TxIdle,
  output logic       TxBusy,
  output logic       CE_TxSM
);

  typedef enum logic [2:0] {Idle, Start, Shift, Parity, Stop1, Stop2} state_t;

  localparam logic [DIV_BITS-1:0] BCNT_ONE = 1;

  state_t              state;
  logic [7:0]          tsr;
  logic [DIV_BITS-1:0] bCnt;
  logic [2:0]          bitCnt;
  logic                lenQ, stopQ, parEnQ, parBit;
  logic                breakOn, lastBit, frameEnd, loadReq, dataPar, parNext, lineBit;

`ifdef UART_TX_BREAK_EN
  assign breakOn = Break;
`else
  assign breakOn = 1'b0;
`endif

  assign CE_TxSM  = CE_16x & (&bCnt);
  assign lastBit  = lenQ ? (bitCnt == 3'd7) : (bitCnt == 3'd6);
  assign frameEnd = CE_TxSM & (((state == Stop1) & ~stopQ) | (state == Stop2));
  // A new character loads either from Idle on any CE_16x or straight off the last stop bit.
  assign loadReq  = ~THR_EF & ~breakOn & (((state == Idle) & CE_16x) | frameEnd);
  assign RE_THR   = Rst & loadReq;
  assign TxIdle   = (state == Idle);
  assign TxBusy   = ~TxIdle;

  assign dataPar = Len ? (^THR) : (^THR[6:0]);

  always_comb begin
    parNext = 1'b0;
    case (Par)
      2'b00:   parNext = ~dataPar;
      2'b01:   parNext = dataPar;
      2'b10:   parNext = 1'b1;
      default: parNext = 1'b0;
    endcase
  end

  always_comb begin
    lineBit = 1'b1;
    case (state)
      Start:   lineBit = 1'b0;
      Shift:   lineBit = tsr[0];
      Parity:  lineBit = parBit;
      default: lineBit = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state  <= Idle;
      tsr    <= '0;
      bCnt   <= '0;
      bitCnt <= '0;
      lenQ   <= 1'b1;
      stopQ  <= 1'b0;
      parEnQ <= 1'b0;
      parBit <= 1'b0;
      TxD    <= 1'b1;
    end else begin
      TxD <= breakOn ? 1'b0 : lineBit;
      if (loadReq) begin
        state  <= Start;
        tsr    <= THR;
        bCnt   <= '0;
        lenQ   <= Len;
        stopQ  <= NumStop;
        parEnQ <= ParEn;
        parBit <= parNext;
      end else if ((state != Idle) && CE_16x) begin
        bCnt <= bCnt + BCNT_ONE;
        if (CE_TxSM) begin
          case (state)
            Start: begin
              state  <= Shift;
              bitCnt <= 3'd0;
            end
            Shift: begin
              tsr    <= tsr >> 1;
              bitCnt <= bitCnt + 3'd1;
              if (lastBit) state <= parEnQ ? Parity : Stop1;
            end
            Parity:  state <= Stop1;
            Stop1:   state <= stopQ ? Stop2 : Idle;
            default: state <= Idle;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_txsm.sv
// Directed bench for uart_txsm: FIFO model, CE_16x every 4 Clk, TxD sampled mid-bit.
module tb_uart_txsm;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       CE_16x = 1'b0;
  logic       Len = 1'b1;
  logic       NumStop = 1'b0;
  logic       ParEn = 1'b0;
  logic [1:0] Par = 2'b00;
  logic [7:0] THR = 8'h00;
  logic       THR_EF = 1'b1;
`ifdef UART_TX_BREAK_EN
  logic       Brk = 1'b0;
`endif
  logic       RE_THR, TxD, TxIdle, TxBusy, CE_TxSM;

  int         checks = 0;
  int         errors = 0;
  int         ceTotal = 0;
  int         reCnt = 0;
  int         reBad = 0;
  int         ceDiv = 0;
  int         loadCe[$];
  logic [7:0] fifo[$];
  bit         popPend = 1'b0;

  uart_txsm #(.DIV_BITS(4)) dut (
    .Clk(Clk), .Rst(Rst), .CE_16x(CE_16x), .Len(Len), .NumStop(NumStop),
    .ParEn(ParEn), .Par(Par), .THR(THR), .THR_EF(THR_EF),
`ifdef UART_TX_BREAK_EN
    .Break(Brk),
`endif
    .RE_THR(RE_THR), .TxD(TxD), .TxIdle(TxIdle), .TxBusy(TxBusy), .CE_TxSM(CE_TxSM)
  );

  initial forever #5 Clk = ~Clk;

  initial forever begin
    @(posedge Clk);
    if (CE_16x) ceTotal++;
  end

  // FIFO model and CE generator; RE_THR observed mid-low-phase, popped after the edge.
  initial forever begin
    @(negedge Clk);
    if (popPend) begin
      void'(fifo.pop_front());
      popPend = 1'b0;
    end
    ceDiv  = (ceDiv + 1) % 4;
    CE_16x = (ceDiv == 0);
    THR_EF = (fifo.size() == 0);
    THR    = (fifo.size() != 0) ? fifo[0] : 8'h00;
    #2;
    if (RE_THR) begin
      reCnt++;
      popPend = 1'b1;
      loadCe.push_back(ceTotal + 1);
      if (THR_EF) reBad++;
    end
  end

  task automatic tick();
    @(negedge Clk);
    #3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitCe(input int target, input string tag);
    int n = 0;
    while (ceTotal < target && n < 20000) begin
      tick();
      n++;
    end
    chk({tag, " ce timeout"}, 32'(ceTotal >= target), 32'd1);
  endtask

  task automatic waitLoad(input int idx);
    int n = 0;
    while (loadCe.size() <= idx && n < 2000) begin
      tick();
      n++;
    end
    chk($sformatf("load%0d timeout", idx), 32'(loadCe.size() > idx), 32'd1);
  endtask

  task automatic frame(input string tag, input int idx, input logic [15:0] exp,
                       input int nb, input bit toIdle);
    int L;
    waitLoad(idx);
    if (loadCe.size() <= idx) return;
    L = loadCe[idx];
    for (int i = 0; i < nb; i++) begin
      waitCe(L + 16 * i + 8, tag);
      chk($sformatf("%s bit%0d", tag, i), 32'(TxD), 32'(exp[i]));
    end
    waitCe(L + 16 * nb - 1, tag);
    chk({tag, " busy at last pulse"}, 32'(TxBusy), 32'd1);
    waitCe(L + 16 * nb, tag);
    if (toIdle) begin
      chk({tag, " idle at frame end"}, 32'(TxIdle), 32'd1);
    end else begin
      chk({tag, " reload at frame end"},
          (loadCe.size() > idx + 1) ? 32'(loadCe[idx + 1]) : 32'hFFFF_FFFF, 32'(L + 16 * nb));
      chk({tag, " busy across reload"}, 32'(TxBusy), 32'd1);
    end
  endtask

  initial begin
    int L;
    // Reset with a character already waiting: nothing may be popped.
    fifo.push_back(8'h55);
    repeat (4) tick();
    chk("rst TxD", 32'(TxD), 32'd1);
    chk("rst TxIdle", 32'(TxIdle), 32'd1);
    chk("rst TxBusy", 32'(TxBusy), 32'd0);
    chk("rst RE_THR", 32'(RE_THR), 32'd0);
    chk("rst reCnt", 32'(reCnt), 32'd0);

    // 8N1 0x55
    Rst = 1'b1;
    frame("8N1_55", 0, 16'h02AA, 10, 1'b1);
    chk("8N1 pops", 32'(reCnt), 32'd1);

    // 8O1 0xA3, parity 1
    ParEn = 1'b1; Par = 2'b00;
    fifo.push_back(8'hA3);
    frame("8O1_A3", 1, 16'h0746, 11, 1'b1);

    // 7E2 0xC1, THR[7] ignored, parity 0
    Len = 1'b0; Par = 2'b01; NumStop = 1'b1;
    fifo.push_back(8'hC1);
    frame("7E2_C1", 2, 16'h0682, 11, 1'b1);

    // Back-to-back 8N1 0x00 then 0xFF
    Len = 1'b1; ParEn = 1'b0; NumStop = 1'b0;
    fifo.push_back(8'h00);
    fifo.push_back(8'hFF);
    frame("b2b_00", 3, 16'h0200, 10, 1'b0);
    frame("b2b_FF", 4, 16'h03FE, 10, 1'b1);
    chk("b2b pops", 32'(reCnt), 32'd5);

    // Mark parity, then scramble format mid-frame
    ParEn = 1'b1; Par = 2'b10;
    fifo.push_back(8'h00);
    waitLoad(5);
    tick();
    tick();
    Par = 2'b11; Len = 1'b0; NumStop = 1'b1; ParEn = 1'b0;
    frame("mark_00", 5, 16'h0600, 11, 1'b1);

    // Space parity
    Len = 1'b1; ParEn = 1'b1; NumStop = 1'b0; Par = 2'b11;
    fifo.push_back(8'h00);
    frame("space_00", 6, 16'h0400, 11, 1'b1);

    // Reset during data bit 3 of 0x0F
    ParEn = 1'b0;
    fifo.push_back(8'h0F);
    waitLoad(7);
    L = (loadCe.size() > 7) ? loadCe[7] : ceTotal;
    waitCe(L + 16 * 4 + 8, "midrst");
    chk("midrst busy before", 32'(TxIdle), 32'd0);
    Rst = 1'b0;
    #1;
    chk("midrst TxD async", 32'(TxD), 32'd1);
    chk("midrst TxIdle async", 32'(TxIdle), 32'd1);
    chk("midrst RE_THR", 32'(RE_THR), 32'd0);
    repeat (5) tick();
    Rst = 1'b1;
    repeat (200) tick();
    chk("post rst pops", 32'(reCnt), 32'd8);
    chk("post rst TxD", 32'(TxD), 32'd1);
    chk("post rst TxIdle", 32'(TxIdle), 32'd1);
    chk("RE_THR while empty", 32'(reBad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_txsm.md
Name: uart_txsm

Overview:
UART transmit state machine; the transmit-side counterpart of the UART_RXSM receive state machine. It pops characters from the transmit holding register (THR) FIFO and serialises them on TxD. Frame format: start bit, 7/8 data bits LSB first, optional parity, then 1/2 stop bits. Bit timing comes from the shared CE_16x clock enable, and the block sits between the THR FIFO and the UART TxD pin.

Parameters:
DIV_BITS, 4, width of bit-time divider; bit time = 2^DIV_BITS CE_16x pulses (16 by default)

Ports:
Clk  input  1  system clock, all state on rising edge
Rst  input  1  asynchronous, active-low reset
CE_16x  input  1  one-Clk-wide enable at 16x baud rate
Len  input  1  0 = 7 data bits, 1 = 8 data bits
NumStop  input  1  0 = 1 stop bit, 1 = 2 stop bits
ParEn  input  1  1 = parity bit transmitted
Par  input  2  00 odd, 01 even, 10 mark (1), 11 space (0)
THR  input  8  FIFO head data, valid while THR_EF = 0
THR_EF  input  1  THR FIFO empty flag
RE_THR  output  1  one-Clk FIFO pop strobe
TxD  output  1  serial line, registered, idle high
TxIdle  output  1  state == Idle
TxBusy  output  1  character in progress (~TxIdle)
CE_TxSM  output  1  bit-boundary enable: CE_16x & (BCnt == all ones)

Behaviour:
- Reset (Rst = 0, async): state Idle, TSR = 0, BCnt = 0, BitCnt = 0, TxD = 1, RE_THR = 0, TxIdle = 1, TxBusy = 0.
- BCnt[DIV_BITS-1:0]: cleared on load; increments on CE_16x; wraps from all ones to 0. CE_TxSM fires at the wrap.
- States: Idle, Start, Shift, Parity, Stop1, Stop2. One-hot or encoded; only TxIdle is exported.
- Idle: TxD = 1. On CE_16x & ~THR_EF:
  - RE_THR = 1 for that Clk cycle.
  - TSR <= THR; BCnt <= 0; next state Start.
  - Format inputs (Len, ParEn, Par, NumStop) are latched into shadow regs at this load and used for the whole frame.
- Start: TxD = 0. On CE_TxSM -> Shift with BitCnt = 0.
- Shift: TxD = TSR[0]. On CE_TxSM:
  - TSR shifts right; BitCnt increments.
  - Leave after the last data bit (BitCnt = 6 when Len = 0, BitCnt = 7 when Len = 1): to Parity if ParEn, else to Stop1.
- Parity: TxD = parity bit, computed over the 7 or 8 data bits at load time.
  - Odd: bit makes total ones (data + parity) odd.
  - Even: makes it even.
  - Mark: 1. Space: 0.
  - On CE_TxSM -> Stop1.
- Stop1: TxD = 1. On CE_TxSM -> Stop2 if NumStop, else end-of-frame.
- Stop2: TxD = 1. On CE_TxSM -> end-of-frame.
- End-of-frame:
  - If ~THR_EF: RE_THR pulses in the same cycle, reload, go directly to Start (no idle gap).
  - Else: go to Idle.
- TxD is registered: it changes one Clk after the state/TSR update, and every bit lasts exactly 2^DIV_BITS CE_16x pulses.
- Len = 0: THR[7] is ignored for both data and parity.
- Format inputs changing mid-frame: no effect until the next load.
- THR_EF deasserting mid-frame: no effect until end-of-frame.
- RE_THR is never asserted while THR_EF = 1 and is never asserted twice per character.
- Reset mid-frame: immediate Idle, TxD = 1; the partial character is lost; no RE_THR.
- CE_16x held low: the FSM freezes and holds TxD.

Optional Feature:
Macro: UART_TX_BREAK_EN.
- Defined:
  - Adds input Break (1 bit).
  - While Break = 1, TxD is forced to 0 (registered, takes effect next Clk).
  - The FSM does not leave Idle, so no RE_THR is issued.
  - A frame in progress keeps sequencing internally, but its line bits are overridden.
  - On Break deassertion, TxD returns to the FSM value next Clk.
- Undefined: no Break port; TxD is purely FSM-driven.

Test Plan:
- 8N1, THR = 0x55, one entry, CE_16x every 4 Clk:
  - RE_THR pulses once.
  - TxD = 0,1,0,1,0,1,0,1,0,1, each bit held 16 CE_16x.
  - Returns to TxIdle = 1 after 160 CE_16x.
- 8O1 (ParEn = 1, Par = 00), THR = 0xA3: data 1,1,0,0,0,1,0,1, parity bit = 1, one stop bit; frame = 176 CE_16x.
- 7E2 (Len = 0, Par = 01), THR = 0xC1:
  - Data 1,0,0,0,0,0,1; THR[7] ignored.
  - Parity = 0, two stop bits (TxD = 1 for 32 CE_16x); frame = 176 CE_16x.
- Back-to-back, 8N1, FIFO holds 0x00 then 0xFF: second RE_THR coincides with the end of the first stop bit; the start bit follows immediately with no extra idle time; 2 RE_THR pulses total.
- Rst asserted during data bit 3 of 0x0F: TxD = 1 and TxIdle = 1 asynchronously; after release with THR_EF = 1, no RE_THR and TxD stays 1.
- Mark/space parity, 8-bit, THR = 0x00: with Par = 10 the parity bit is 1; with Par = 11 the parity bit is 0. Changing Par mid-frame does not affect the current frame.
